key_sched192_ctrl: RTL and testbench
====================================

Name: key_sched192_ctrl

Overview:
Sequencer for the AES-192 six-word key-expansion step, a combinational datapath that takes (key block, rCon) and returns the next 192-bit block. It iterates the step 8 times and repacks the 6-word blocks into the 13 AES-192 round keys of 128 bits each. Round keys are streamed over a valid/ready interface to the cipher round datapath. The expansion datapath sits outside this block and is reached through the exp_* ports.

Parameters:
NUM_RK, 13, number of round keys emitted per schedule (fixed for AES-192)
NUM_ITER, 8, number of expansion-step invocations per schedule

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a schedule; sampled only in IDLE
key_in  in  192  cipher key; word w0 = key_in[191:160]
exp_key_o  out  192  block driven to the expansion datapath
exp_rcon_o  out  32  rCon to the expansion datapath, {rc,24'h0}
exp_key_i  in  192  next block returned combinationally, same cycle
rk_valid  out  1  round key available
rk_ready  in  1  consumer accepts
rk_data  out  128  round key; lowest-index word in [127:96]
rk_index  out  4  round-key number, 0..12
busy  out  1  schedule in progress
done  out  1  one-cycle pulse after round key 12 is accepted

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, all outputs 0, word buffer cleared, cnt=0, iter=0, rc=8'h01, rk_index=0.
- States are IDLE and RUN.
- IDLE with start=1:
  - buf = key_in (6 words), cnt=6, blk=key_in, iter=0, rc=01, rk_index=0.
  - Next state is RUN; busy=1 from the next cycle.
  - Latency from start to first rk_valid is 1 cycle.
- Word buffer: 8 x 32-bit, ordered oldest first; cnt is 0..8.
  - rk_valid = RUN && cnt>=4.
  - rk_data = the oldest 4 words, registered, stable while valid && !ready.
- fire = rk_valid && rk_ready. On fire, the oldest 4 words are dropped and rk_index increments.
- step = RUN && iter<NUM_ITER && (cnt - 4*fire) < 4. On step:
  - Append exp_key_i's 6 words ([191:160] first) after the surviving words.
  - blk <= exp_key_i, iter++, rc <= xtime(rc).
  - rc sequence is 01,02,04,08,10,20,40,80.
- fire and step may occur in the same cycle: cnt_next = cnt - 4*fire + 6*step. cnt never exceeds 8.
- exp_key_o = blk and exp_rcon_o = {rc,24'h0}, both continuously driven.
- With rk_ready held high, one round key is emitted per cycle with no bubbles. Steps occur on 2 of every 3 fires.
- Backpressure: while rk_ready=0, nothing changes. cnt>=4 holds, so no step occurs.
- Termination: the fire with rk_index=12 moves the block to IDLE on the next edge.
  - done=1 for exactly that next cycle; busy=0 and rk_valid=0 in that cycle.
  - The 2 leftover words from the 8th step are discarded; cnt is cleared.
- start during RUN is ignored. start in the same cycle as done is accepted (done is registered; the block is already in IDLE).
- rst_n low mid-schedule: immediate return to reset values. No done is produced and no partial stream resumes.
- rk_valid never drops without a fire except through reset.

Test Plan:
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, rk_ready=1 -> 13 consecutive rk_valid cycles starting 1 cycle after start.
  - rk0 = 8e73b0f7da0e6452c810f32b809079e5.
  - rk1 = 62f8ead2522c6b7bfe0c91f72402f5a5.
  - rk2 = ec12068e6c827f6b0e7a95b95c56fec2.
  - rk12 = e98ba06f448c773c8ecc720401002202.
  - done pulses the cycle after rk12.
- Same key with rk_ready toggling 1,0,0,1 repeating -> identical rk_data and rk_index sequence. rk_data holds during stalls; exp_rcon_o advances only on steps, ending at 80000000.
- start pulsed at cycle 5 of RUN with a different key -> ignored; the original stream completes unchanged.
- rst_n asserted after rk_index=6 is accepted -> all outputs 0 immediately, no done. A fresh start then gives rk0 = key_in[191:64] again.
- start asserted in the done cycle -> new schedule begins; rk_valid rises 1 cycle later with rk_index=0.
- All-zero key -> rk1 = 00000000000000006263636362636363. Observed rc values are 01,02,04,08,10,20,40,80 across the 8 steps.

Source files
------------

// File: rtl/key_sched192_ctrl.sv
// key_sched192_ctrl: AES-192 key-schedule sequencer.
// Drives an external six-word expansion step (exp_key_o/exp_rcon_o -> exp_key_i)
// eight times and repacks the resulting 32-bit words into the thirteen 128-bit
// round keys, streamed over a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, key_in         begin a schedule with a 192-bit cipher key (w0 = [191:160])
//   exp_key_o, exp_rcon_o current block and {rc,24'h0} to the expansion datapath
//   exp_key_i             next block from the expansion datapath (same cycle)
//   rk_valid, rk_ready    round-key handshake
//   rk_data, rk_index     round key (lowest word in [127:96]) and its number 0..12
//   busy, done            schedule in progress / one-cycle completion pulse
module key_sched192_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [191:0] key_in,
  output logic [191:0] exp_key_o,
  output logic [31:0]  exp_rcon_o,
  input  logic [191:0] exp_key_i,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  localparam int unsigned NUM_RK    = 13;
  localparam int unsigned NUM_ITER  = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLK_WORDS = 6;
  localparam int unsigned RK_WORDS  = 4;
  localparam int unsigned BUF_DEPTH = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned RC_W      = 8;

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [WORD_W-1:0]      r_buf [BUF_DEPTH];
  logic [WORD_W-1:0]      w_buf_nxt [BUF_DEPTH];
  logic [WORD_W-1:0]      w_buf_upd [BUF_DEPTH];
  logic [WORD_W-1:0]      w_new [BLK_WORDS];
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_keep;
  logic [191:0]           r_blk, w_blk_nxt;
  logic [CNT_W-1:0]       r_iter, w_iter_nxt;
  logic [RC_W-1:0]        r_rc, w_rc_nxt, w_rc_x;
  logic [IDX_W-1:0]       r_rk_index, w_idx_nxt;
  logic [127:0]           r_rk_data, w_rk_data_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   w_fire, w_step, w_last;

  assign exp_key_o  = r_blk;
  assign exp_rcon_o = {r_rc, 24'h0};
  assign rk_valid   = r_valid;
  assign rk_data    = r_rk_data;
  assign rk_index   = r_rk_index;
  assign busy       = r_busy;
  assign done       = r_done;

  // Handshake and expansion-step qualifiers.
  assign w_fire = r_valid & rk_ready;
  assign w_keep = r_cnt - (w_fire ? CNT_W'(RK_WORDS) : CNT_W'(0));
  assign w_step = (r_state == S_RUN) && (r_iter < CNT_W'(NUM_ITER)) && (w_keep < CNT_W'(RK_WORDS));
  assign w_last = w_fire && (r_rk_index == IDX_W'(NUM_RK - 1));
  assign w_rc_x = {r_rc[RC_W-2:0], 1'b0} ^ (r_rc[RC_W-1] ? 8'h1b : 8'h00);

  // Split the returned block into words, oldest first.
  always_comb begin
    for (int k = 0; k < BLK_WORDS; k++) begin
      w_new[k] = exp_key_i[WORD_W*(BLK_WORDS-1-k) +: WORD_W];
    end
  end

  // Word buffer: drop a round key on fire, then append a new block behind the survivors.
  always_comb begin
    w_buf_upd = r_buf;
    if (w_fire) begin
      for (int i = 0; i < BUF_DEPTH - RK_WORDS; i++) begin
        w_buf_upd[i] = r_buf[i + RK_WORDS];
      end
      for (int i = BUF_DEPTH - RK_WORDS; i < BUF_DEPTH; i++) begin
        w_buf_upd[i] = '0;
      end
    end
    if (w_step) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if ((i >= int'(w_keep)) && (i < int'(w_keep) + int'(BLK_WORDS))) begin
          w_buf_upd[i] = w_new[3'(i - int'(w_keep))];
        end
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_blk_nxt   = r_blk;
    w_iter_nxt  = r_iter;
    w_rc_nxt    = r_rc;
    w_idx_nxt   = r_rk_index;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < BLK_WORDS; i++) begin
            w_buf_nxt[i] = key_in[WORD_W*(BLK_WORDS-1-i) +: WORD_W];
          end
          for (int i = BLK_WORDS; i < BUF_DEPTH; i++) begin
            w_buf_nxt[i] = '0;
          end
          w_cnt_nxt   = CNT_W'(BLK_WORDS);
          w_blk_nxt   = key_in;
          w_iter_nxt  = '0;
          w_rc_nxt    = 8'h01;
          w_idx_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_buf_nxt = w_buf_upd;
        w_cnt_nxt = w_keep + (w_step ? CNT_W'(BLK_WORDS) : CNT_W'(0));
        if (w_step) begin
          w_blk_nxt  = exp_key_i;
          w_iter_nxt = r_iter + CNT_W'(1);
          // rc parks at 80 after the final step instead of wrapping to 1b.
          w_rc_nxt   = (r_iter == CNT_W'(NUM_ITER - 1)) ? r_rc : w_rc_x;
        end
        if (w_fire) begin
          w_idx_nxt = r_rk_index + IDX_W'(1);
        end
        if (w_last) begin
          // Leftover words from the last step are discarded.
          for (int i = 0; i < BUF_DEPTH; i++) begin
            w_buf_nxt[i] = '0;
          end
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_valid_nxt   = (w_state_nxt == S_RUN) && (w_cnt_nxt >= CNT_W'(RK_WORDS));
    w_busy_nxt    = (w_state_nxt == S_RUN);
    w_rk_data_nxt = {w_buf_nxt[0], w_buf_nxt[1], w_buf_nxt[2], w_buf_nxt[3]};
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_cnt      <= '0;
      r_blk      <= '0;
      r_iter     <= '0;
      r_rc       <= 8'h01;
      r_rk_index <= '0;
      r_rk_data  <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf      <= w_buf_nxt;
      r_cnt      <= w_cnt_nxt;
      r_blk      <= w_blk_nxt;
      r_iter     <= w_iter_nxt;
      r_rc       <= w_rc_nxt;
      r_rk_index <= w_idx_nxt;
      r_rk_data  <= w_rk_data_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_key_sched192_ctrl.sv
// Testbench for key_sched192_ctrl: provides the AES-192 expansion step as the
// external datapath and scoreboards the round-key stream.
module tb_key_sched192_ctrl;

  localparam logic [191:0] KEY_A = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] KEY_B = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] KEY_Z = 192'h0;

  localparam logic [7:0] RCT [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [191:0] key_in = '0;
  logic [191:0] exp_key_o;
  logic [31:0]  exp_rcon_o;
  logic [191:0] exp_key_i;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;

  int n_total = 0;
  int n_bad   = 0;
  int n_fire  = 0;
  exp_t exp_q[$];
  logic [31:0] rc_log[$];
  bit           holding = 1'b0;
  logic [127:0] held_data = '0;

  key_sched192_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .exp_key_o(exp_key_o), .exp_rcon_o(exp_rcon_o), .exp_key_i(exp_key_i),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
  endfunction

  // External six-word expansion step.
  function automatic logic [191:0] step6(input logic [191:0] b, input logic [31:0] rcon);
    logic [31:0] w [6];
    logic [31:0] n [6];
    for (int j = 0; j < 6; j++) w[j] = b[32*(5-j) +: 32];
    n[0] = w[0] ^ sub_rot(w[5]) ^ rcon;
    for (int j = 1; j < 6; j++) n[j] = w[j] ^ n[j-1];
    return {n[0], n[1], n[2], n[3], n[4], n[5]};
  endfunction

  always_comb exp_key_i = step6(exp_key_o, exp_rcon_o);

  // Reference word-by-word AES-192 expansion.
  function automatic logic [127:0] ref_rk(input logic [191:0] key, input int idx);
    logic [31:0] w [52];
    logic [31:0] t;
    for (int i = 0; i < 6; i++) w[i] = key[32*(5-i) +: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) t = sub_rot(t) ^ {RCT[i/6-1], 24'h0};
      w[i] = w[i-6] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  // Published vectors take precedence over the reference model.
  function automatic logic [127:0] expected_rk(input logic [191:0] key, input int idx);
    if (key == KEY_A && idx == 0)  return 128'h8e73b0f7da0e6452c810f32b809079e5;
    if (key == KEY_A && idx == 1)  return 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    if (key == KEY_A && idx == 2)  return 128'hec12068e6c827f6b0e7a95b95c56fec2;
    if (key == KEY_A && idx == 12) return 128'he98ba06f448c773c8ecc720401002202;
    if (key == KEY_Z && idx == 1)  return 128'h00000000000000006263636362636363;
    return ref_rk(key, idx);
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_schedule(input logic [191:0] key);
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      e.idx  = 4'(i);
      e.data = expected_rk(key, i);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pop and compare on every accepted round key; check hold under stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (holding && rk_valid) check("stall_hold", {64'h0, rk_data}, {64'h0, held_data});
      if (rk_valid && rk_ready) begin
        n_fire++;
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_rk: got index %0d data %h expected none", rk_index, rk_data);
        end else begin
          e = exp_q.pop_front();
          check("rk_data", {64'h0, rk_data}, {64'h0, e.data});
          check("rk_index", {188'h0, rk_index}, {188'h0, e.idx});
        end
      end
      holding   = rk_valid && !rk_ready;
      held_data = rk_data;
    end
  end

  // Record each distinct rCon presented while a schedule runs.
  always @(negedge clk) begin
    if (rst_n && busy) begin
      if (rc_log.size() == 0 || rc_log[$] != exp_rcon_o) rc_log.push_back(exp_rcon_o);
    end
  end

  task automatic start_pulse(input logic [191:0] k);
    @(posedge clk); #1;
    start  = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Drive rk_ready (mode 0: always high, mode 1: 1,0,0,1 repeating) until done.
  task automatic run_stream(input int mode, input int start_at, input logic [191:0] skey,
                            output int vcnt, output int done_cyc);
    int c;
    bit got;
    c = 0; got = 1'b0; vcnt = 0; done_cyc = -1;
    while (!got && c < 300) begin
      rk_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      start    = (c == start_at);
      if (c == start_at) key_in = skey;
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        done_cyc = c;
        check("done_busy", {191'h0, busy}, 192'h0);
        check("done_valid", {191'h0, rk_valid}, 192'h0);
      end else begin
        if (rk_valid) vcnt++;
        @(posedge clk); #1;
        c++;
      end
    end
    start    = 1'b0;
    rk_ready = 1'b1;
    if (!got) begin
      n_total++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, dcyc, dsum;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {191'h0, rk_valid}, 192'h0);
    check("rst_busy", {191'h0, busy}, 192'h0);
    check("rst_done", {191'h0, done}, 192'h0);
    check("rst_index", {188'h0, rk_index}, 192'h0);
    check("rst_data", {64'h0, rk_data}, 192'h0);
    check("rst_key", exp_key_o, 192'h0);
    check("rst_rcon", {160'h0, exp_rcon_o}, {160'h0, 32'h01000000});
    rst_n = 1'b1;

    // FIPS-197 key, consumer always ready.
    push_schedule(KEY_A);
    start_pulse(KEY_A);
    check("lat_valid", {191'h0, rk_valid}, {191'h0, 1'b1});
    check("lat_index", {188'h0, rk_index}, 192'h0);
    check("lat_busy", {191'h0, busy}, {191'h0, 1'b1});
    check("lat_expkey", exp_key_o, KEY_A);
    check("lat_rcon", {160'h0, exp_rcon_o}, {160'h0, 32'h01000000});
    run_stream(0, -1, KEY_Z, vcnt, dcyc);
    check("a_valid_cycles", 192'(vcnt), 192'd13);
    check("a_done_cycle", 192'(dcyc), 192'd13);
    check("a_queue_empty", 192'(exp_q.size()), 192'd0);
    @(posedge clk); #1;
    check("a_done_pulse", {191'h0, done}, 192'h0);

    // Same key with 1,0,0,1 backpressure.
    push_schedule(KEY_A);
    start_pulse(KEY_A);
    run_stream(1, -1, KEY_Z, vcnt, dcyc);
    check("bp_done_cycle", 192'(dcyc), 192'd25);
    check("bp_valid_cycles", 192'(vcnt), 192'd25);
    check("bp_rcon_end", {160'h0, exp_rcon_o}, {160'h0, 32'h80000000});
    check("bp_queue_empty", 192'(exp_q.size()), 192'd0);

    // start during RUN with another key must be ignored.
    push_schedule(KEY_A);
    start_pulse(KEY_A);
    run_stream(0, 5, KEY_B, vcnt, dcyc);
    check("ign_done_cycle", 192'(dcyc), 192'd13);
    check("ign_queue_empty", 192'(exp_q.size()), 192'd0);
    @(posedge clk); #1;
    check("ign_idle", {191'h0, busy}, 192'h0);

    // Reset after round key 6 is accepted.
    push_schedule(KEY_A);
    start_pulse(KEY_A);
    repeat (7) @(posedge clk);
    #1;
    check("mid_index", {188'h0, rk_index}, {188'h0, 4'd7});
    rst_n = 1'b0;
    #1;
    check("mr_valid", {191'h0, rk_valid}, 192'h0);
    check("mr_busy", {191'h0, busy}, 192'h0);
    check("mr_done", {191'h0, done}, 192'h0);
    check("mr_index", {188'h0, rk_index}, 192'h0);
    check("mr_data", {64'h0, rk_data}, 192'h0);
    check("mr_key", exp_key_o, 192'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    dsum = 0;
    repeat (3) begin
      @(negedge clk);
      dsum += int'(done) + int'(rk_valid);
    end
    check("mr_quiet", 192'(dsum), 192'd0);
    push_schedule(KEY_A);
    start_pulse(KEY_A);
    run_stream(0, -1, KEY_Z, vcnt, dcyc);
    check("mr_done_cycle", 192'(dcyc), 192'd13);

    // start in the done cycle launches a new (all-zero key) schedule.
    rc_log.delete();
    push_schedule(KEY_Z);
    start  = 1'b1;
    key_in = KEY_Z;
    @(posedge clk); #1;
    start  = 1'b0;
    check("dn_valid", {191'h0, rk_valid}, {191'h0, 1'b1});
    check("dn_index", {188'h0, rk_index}, 192'h0);
    run_stream(0, -1, KEY_Z, vcnt, dcyc);
    check("z_done_cycle", 192'(dcyc), 192'd13);
    check("z_queue_empty", 192'(exp_q.size()), 192'd0);
    check("z_rc_count", 192'(rc_log.size()), 192'd8);
    for (int i = 0; i < 8 && i < rc_log.size(); i++) begin
      check("z_rc_value", {160'h0, rc_log[i]}, {160'h0, RCT[i], 24'h0});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
